pdm_tx: RTL and testbench

- PDM transmitter: the write-side counterpart of the per-channel PDM receive/decimate path.
- Software writes signed 16-bit PCM samples over the same per-channel 16-bit register slice used by the sonar channels.
- A small FIFO buffers the samples. Each sample is consumed on ce_pcm and converted to a 1-bit stream by a first-order sigma-delta modulator clocked on ce_pdm.
- Used as the ping/test-tone source and for loopback checking of receive channels. pdm_data_o drives an io_out pad.

---
 rtl/pdm_tx_if.sv | 27 ++
 rtl/pdm_tx.sv | 178 +++++++++++++++++
 tb/tb_pdm_tx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_tx_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pdm_tx_if : register-slice handshake between address decode and the   |
// |             PDM transmitter channel.                                  |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
interface pdm_tx_if #(
   parameter int BUS_WIDTH = 16
);
   logic                 wb_valid_i;
   logic [3:0]           wbs_adr_i;
   logic [BUS_WIDTH-1:0] wbs_dat_i;
   logic                 wbs_strb_i;
   logic                 wbs_ack_o;
   logic [BUS_WIDTH-1:0] wbs_dat_o;

   modport master (
      output wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface
`default_nettype wire

// File: rtl/pdm_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pdm_tx : PCM sample FIFO feeding a first-order sigma-delta modulator.  |
// |          Optional dither LFSR enabled by defining PDM_TX_DITHER_EN.   |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module pdm_tx #(
   parameter int BUS_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  wire      wb_clk_i,
   input  wire      wb_rst_i,
   pdm_tx_if.slave  bus,
   input  wire      ce_pdm,
   input  wire      ce_pcm,
   output logic     pdm_data_o,
   output logic     underrun_o
);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LVL_W = AW + 1;
   localparam int ACC_W = BUS_WIDTH + 2;
   localparam logic signed [ACC_W-1:0] C_FB_POS = {3'b000, {(BUS_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] C_FB_NEG = {3'b111, {(BUS_WIDTH-1){1'b0}}};

   logic                    ack_q;
   logic [BUS_WIDTH-1:0]    rdat_q;
   logic                    en_q;
   logic [LVL_W-1:0]        cnt_q;
   logic [AW-1:0]           wr_ptr_q;
   logic [AW-1:0]           rd_ptr_q;
   logic [BUS_WIDTH-1:0]    last_q;
   logic [BUS_WIDTH-1:0]    sample_q;
   logic [BUS_WIDTH-1:0]    sample_d;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic                    y_q;
   logic                    udr_q;
   logic                    ovf_q;
   logic [BUS_WIDTH-1:0]    mem [FIFO_DEPTH];

   logic                    w_access, w_wr, w_wr_ctrl, w_push_req, w_wr_status;
   logic                    w_flush, w_full, w_empty, w_pcm, w_pop, w_push;
   logic                    w_ovf_set, w_udr_set, w_clr_udr, w_clr_ovf;
   logic                    w_dither;
   logic signed [ACC_W-1:0] w_x;
   logic [BUS_WIDTH-1:0]    w_status;
   logic [BUS_WIDTH-1:0]    w_rdata;

   // Side effects only in the cycle the acknowledge is generated.
   assign w_access    = bus.wb_valid_i & ~ack_q;
   assign w_wr        = w_access & bus.wbs_strb_i;
   assign w_wr_ctrl   = w_wr & (bus.wbs_adr_i == 4'd0);
   assign w_push_req  = w_wr & (bus.wbs_adr_i == 4'd1);
   assign w_wr_status = w_wr & (bus.wbs_adr_i == 4'd2);
   assign w_flush     = w_wr_ctrl & bus.wbs_dat_i[1];
   assign w_clr_udr   = w_wr_status & bus.wbs_dat_i[2];
   assign w_clr_ovf   = w_wr_status & bus.wbs_dat_i[3];

   assign w_full    = (cnt_q == LVL_W'(FIFO_DEPTH));
   assign w_empty   = (cnt_q == '0);
   assign w_pcm     = en_q & ce_pcm;
   assign w_pop     = w_pcm & ~w_empty;
   assign w_udr_set = w_pcm & w_empty;
   // A pop frees the head slot in the same cycle, so a full FIFO still takes the push.
   assign w_push    = w_push_req & (~w_full | w_pop);
   assign w_ovf_set = w_push_req & w_full & ~w_pop;

`ifdef PDM_TX_DITHER_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         lfsr_q <= 16'hACE1;
      end else if (en_q && ce_pdm) begin
         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
   end

   assign w_dither = lfsr_q[0];
`else
   assign w_dither = 1'b0;
`endif

   always_comb begin
      sample_d = sample_q;
      if (w_pop) begin
         sample_d = mem[rd_ptr_q];
      end else if (w_udr_set) begin
         sample_d = '0;
      end
   end

   assign w_x   = {{2{sample_d[BUS_WIDTH-1]}}, sample_d} + {{(ACC_W-1){1'b0}}, w_dither};
   assign acc_d = acc_q + w_x - (y_q ? C_FB_POS : C_FB_NEG);

   always_comb begin
      w_status          = '0;
      w_status[0]       = w_full;
      w_status[1]       = w_empty;
      w_status[2]       = udr_q;
      w_status[3]       = ovf_q;
      w_status[4 +: LVL_W] = cnt_q;
   end

   always_comb begin
      w_rdata = '0;
      case (bus.wbs_adr_i)
         4'd0:    w_rdata[0] = en_q;
         4'd1:    w_rdata    = last_q;
         4'd2:    w_rdata    = w_status;
         default: w_rdata    = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (w_push && !w_flush) begin
         mem[wr_ptr_q] <= bus.wbs_dat_i;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q    <= 1'b0;
         rdat_q   <= '0;
         en_q     <= 1'b0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         last_q   <= '0;
         sample_q <= '0;
         acc_q    <= '0;
         y_q      <= 1'b0;
         udr_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         ack_q  <= bus.wb_valid_i & ~ack_q;
         rdat_q <= w_access ? w_rdata : '0;
         if (w_wr_ctrl) begin
            en_q <= bus.wbs_dat_i[0];
         end
         if (w_push) begin
            last_q <= bus.wbs_dat_i;
         end
         if (w_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (w_push && !w_pop) begin
               cnt_q <= cnt_q + 1'b1;
            end else if (w_pop && !w_push) begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
         udr_q <= w_udr_set | (udr_q & ~w_clr_udr);
         ovf_q <= w_ovf_set | (ovf_q & ~w_clr_ovf);
         if (!en_q) begin
            sample_q <= '0;
            acc_q    <= '0;
            y_q      <= 1'b0;
         end else begin
            sample_q <= sample_d;
            if (ce_pdm) begin
               acc_q <= acc_d;
               y_q   <= ~acc_d[ACC_W-1];
            end
         end
      end
   end

   assign bus.wbs_ack_o = ack_q;
   assign bus.wbs_dat_o = rdat_q;
   assign pdm_data_o    = y_q;
   assign underrun_o    = udr_q;
endmodule
`default_nettype wire

// File: tb/tb_pdm_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pdm_tx : directed self-checking bench for pdm_tx.                  |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
module tb_pdm_tx;
   logic clk;
   logic rst;
   logic ce_pdm;
   logic ce_pcm;
   logic pdm_data;
   logic underrun;
   int   n_checks;
   int   n_errors;

   pdm_tx_if #(.BUS_WIDTH(16)) bus ();

   pdm_tx #(.BUS_WIDTH(16), .FIFO_DEPTH(4)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .bus        (bus),
      .ce_pdm     (ce_pdm),
      .ce_pcm     (ce_pcm),
      .pdm_data_o (pdm_data),
      .underrun_o (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One bus access; optionally raises ce_pcm on the commit edge.
   task automatic bus_xfer(input logic wr, input logic [3:0] adr, input logic [15:0] wd,
                           input logic with_pcm, output logic [15:0] rd);
      logic ack_first;
      logic ack_next;
      @(negedge clk);
      bus.wb_valid_i = 1'b1;
      bus.wbs_strb_i = wr;
      bus.wbs_adr_i  = adr;
      bus.wbs_dat_i  = wd;
      if (with_pcm) ce_pcm = 1'b1;
      @(negedge clk);
      ack_first      = bus.wbs_ack_o;
      rd             = bus.wbs_dat_o;
      bus.wb_valid_i = 1'b0;
      bus.wbs_strb_i = 1'b0;
      if (with_pcm) ce_pcm = 1'b0;
      @(negedge clk);
      ack_next = bus.wbs_ack_o;
      chk("ack_once", {30'd0, ack_first, ack_next}, 32'h2);
   endtask

   task automatic wr_reg(input logic [3:0] adr, input logic [15:0] wd);
      logic [15:0] d;
      bus_xfer(1'b1, adr, wd, 1'b0, d);
   endtask

   task automatic rd_check(input string tag, input logic [3:0] adr, input logic [15:0] exp);
      logic [15:0] d;
      bus_xfer(1'b0, adr, 16'h0, 1'b0, d);
      chk(tag, {16'h0, d}, {16'h0, exp});
   endtask

   task automatic pulse_pcm();
      @(negedge clk);
      ce_pcm = 1'b1;
      @(negedge clk);
      ce_pcm = 1'b0;
   endtask

   task automatic pdm_bit(output logic b);
      @(negedge clk);
      ce_pdm = 1'b1;
      @(negedge clk);
      ce_pdm = 1'b0;
      b = pdm_data;
   endtask

   // Restart the modulator from zero state, pop one sample, compare the first 4 bits.
   task automatic pop_check(input string tag, input logic [3:0] exp);
      logic [3:0] bits;
      logic       b;
      wr_reg(4'd0, 16'h0000);
      wr_reg(4'd0, 16'h0001);
      pulse_pcm();
      for (int k = 0; k < 4; k++) begin
         pdm_bit(b);
         bits[3-k] = b;
      end
      chk(tag, {28'd0, bits}, {28'd0, exp});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] bits16;
      logic [7:0]  bits8;
      logic [15:0] d;
      logic        b;
      int          win_ones [16];

      n_checks       = 0;
      n_errors       = 0;
      rst            = 1'b1;
      ce_pdm         = 1'b0;
      ce_pcm         = 1'b0;
      bus.wb_valid_i = 1'b0;
      bus.wbs_adr_i  = 4'd0;
      bus.wbs_dat_i  = 16'h0;
      bus.wbs_strb_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_pdm", {31'd0, pdm_data}, 32'd0);
      chk("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
      chk("rst_udr", {31'd0, underrun}, 32'd0);
      rd_check("rst_status", 4'd2, 16'h0002);
      rd_check("rst_ctrl", 4'd0, 16'h0000);
      rd_check("unmapped", 4'd7, 16'h0000);

      // Empty FIFO underrun, idle tone
      wr_reg(4'd0, 16'h0001);
      pulse_pcm();
      chk("udr_pin", {31'd0, underrun}, 32'd1);
      for (int k = 0; k < 8; k++) begin
         pdm_bit(b);
         bits8[7-k] = b;
      end
      chk("idle_bits", {24'd0, bits8}, {24'd0, 8'b1101_0101});
      rd_check("udr_status", 4'd2, 16'h0006);
      wr_reg(4'd2, 16'h0004);
      rd_check("udr_clr", 4'd2, 16'h0002);
      chk("udr_pin_clr", {31'd0, underrun}, 32'd0);

      // Full-scale positive then negative
      wr_reg(4'd0, 16'h0000);
      wr_reg(4'd1, 16'h7FFF);
      wr_reg(4'd0, 16'h0001);
      pulse_pcm();
      for (int k = 0; k < 16; k++) begin
         pdm_bit(b);
         bits16[15-k] = b;
      end
      chk("pos_fs", {16'd0, bits16}, 32'h0000_FFFF);
      wr_reg(4'd1, 16'h8000);
      pulse_pcm();
      for (int k = 0; k < 8; k++) begin
         pdm_bit(b);
         bits8[7-k] = b;
      end
      chk("neg_fs", {24'd0, bits8}, {24'd0, 8'b1000_0000});
      rd_check("fs_status", 4'd2, 16'h0002);

      // Overflow and FIFO ordering
      wr_reg(4'd0, 16'h0000);
      wr_reg(4'd1, 16'h7FFF);
      wr_reg(4'd1, 16'h8000);
      wr_reg(4'd1, 16'h0000);
      wr_reg(4'd1, 16'hC000);
      wr_reg(4'd1, 16'h1234);
      rd_check("ovf_status", 4'd2, 16'h0049);
      rd_check("last_push", 4'd1, 16'hC000);
      wr_reg(4'd2, 16'h0008);
      rd_check("ovf_clr", 4'd2, 16'h0041);
      pop_check("pop0", 4'b1111);
      pop_check("pop1", 4'b1000);
      pop_check("pop2", 4'b1101);
      pop_check("pop3", 4'b1001);
      rd_check("drained", 4'd2, 16'h0002);

      // Full FIFO: push coinciding with a pop
      wr_reg(4'd0, 16'h0000);
      wr_reg(4'd1, 16'h7FFF);
      wr_reg(4'd1, 16'h8000);
      wr_reg(4'd1, 16'h0000);
      wr_reg(4'd1, 16'hC000);
      wr_reg(4'd0, 16'h0001);
      rd_check("full_pre", 4'd2, 16'h0041);
      bus_xfer(1'b1, 4'd1, 16'h8000, 1'b1, d);
      rd_check("full_pushpop", 4'd2, 16'h0041);
      pop_check("tail0", 4'b1000);
      pop_check("tail1", 4'b1101);
      pop_check("tail2", 4'b1001);
      pop_check("tail3", 4'b1000);
      rd_check("tail_empty", 4'd2, 16'h0002);

      // Flush and CTRL readback
      wr_reg(4'd0, 16'h0000);
      wr_reg(4'd1, 16'h1111);
      wr_reg(4'd1, 16'h2222);
      rd_check("pre_flush", 4'd2, 16'h0020);
      wr_reg(4'd0, 16'h0003);
      rd_check("flushed", 4'd2, 16'h0002);
      rd_check("ctrl_rd", 4'd0, 16'h0001);

      // Long stream of 0x4000 at 64 ce_pdm per ce_pcm, refilled in the background
      wr_reg(4'd0, 16'h0000);
      for (int k = 0; k < 4; k++) wr_reg(4'd1, 16'h4000);
      wr_reg(4'd0, 16'h0001);
      for (int w = 0; w < 16; w++) win_ones[w] = 0;
      fork
         begin
            for (int i = 0; i <= 1024; i++) begin
               @(negedge clk);
               if (i > 0 && pdm_data) win_ones[(i-1)/64]++;
               ce_pdm = (i < 1024);
               ce_pcm = (i < 1024) && (i % 64 == 0);
            end
         end
         begin
            logic [15:0] dd;
            repeat (10) @(negedge clk);
            for (int k = 0; k < 12; k++) begin
               bus_xfer(1'b1, 4'd1, 16'h4000, 1'b0, dd);
               repeat (61) @(negedge clk);
            end
         end
      join
      for (int w = 0; w < 16; w++) begin
         chk($sformatf("density_w%0d", w),
             (win_ones[w] >= 47 && win_ones[w] <= 49) ? 32'd48 : win_ones[w], 32'd48);
      end
      rd_check("stream_status", 4'd2, 16'h0002);

      // Asynchronous reset in the middle of a bus access
      wr_reg(4'd1, 16'h4000);
      wr_reg(4'd1, 16'h4000);
      for (int k = 0; k < 8; k++) begin
         pdm_bit(b);
         if (b) break;
      end
      chk("pre_rst_pdm", {31'd0, pdm_data}, 32'd1);
      @(negedge clk);
      bus.wb_valid_i = 1'b1;
      bus.wbs_strb_i = 1'b0;
      bus.wbs_adr_i  = 4'd2;
      #2 rst = 1'b1;
      #1;
      chk("arst_pdm", {31'd0, pdm_data}, 32'd0);
      chk("arst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
      @(negedge clk);
      chk("arst_noack", {31'd0, bus.wbs_ack_o}, 32'd0);
      bus.wb_valid_i = 1'b0;
      rst = 1'b0;
      rd_check("arst_status", 4'd2, 16'h0002);
      rd_check("arst_ctrl", 4'd0, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
